writeback_stage: RTL
====================

Name: writeback_stage

Overview:
Final pipeline stage, directly upstream of the register file: merges ALU and load/store results into the single regfile write port. Formats load data (byte/half/word, sign/zero extension), arbitrates between the two producers with valid/ready handshakes, and drives registered rd_addr/rd_data/rd_we. Keeps a 32-entry pending-write scoreboard that the issue logic uses for RAW/WAW stalls.

Parameters:
STARVE_LIMIT, 2, consecutive cycles the ALU may lose arbitration before it is granted priority.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
alu_valid_i  input  1  ALU result valid
alu_ready_o  output  1  ALU result accepted this cycle
alu_rd_addr_i  input  5  ALU destination register
alu_result_i  input  32  ALU result
lsu_valid_i  input  1  load data valid
lsu_ready_o  output  1  load data accepted this cycle
lsu_rd_addr_i  input  5  load destination register
lsu_rdata_i  input  32  raw aligned memory word
lsu_size_i  input  2  00 byte, 01 half, 10 word (11 treated as word)
lsu_unsigned_i  input  1  1 = zero-extend, 0 = sign-extend
lsu_offset_i  input  2  byte offset of the access within the word
issue_i  input  1  instruction with destination issued this cycle
issue_rd_addr_i  input  5  destination of the issued instruction
rs_addr_a_i  input  5  source A of the instruction in decode
rs_addr_b_i  input  5  source B of the instruction in decode
rd_addr_o  output  5  regfile write address
rd_data_o  output  32  regfile write data
rd_we_o  output  1  regfile write enable
busy_o  output  32  pending-write bitmap; bit 0 always 0
stall_o  output  1  decode must hold (hazard)

Behaviour:
- Reset (async, rst_ni low): rd_addr_o=0, rd_data_o=0, rd_we_o=0, busy_o=0, starve counter=0. All state returns to these values immediately when reset asserts mid-operation; pending results are discarded.
- Handshake: a transfer occurs when valid and ready are both high at the rising edge. Ready is combinational from the arbiter; only one of alu_ready_o and lsu_ready_o is high in any cycle. Producers hold valid and data stable until accepted.
- Arbitration: the LSU wins by default. The starve counter increments each cycle the ALU is valid but not granted, and resets to 0 whenever the ALU is granted or is not valid. When counter == STARVE_LIMIT, the ALU wins. With a single requester, that requester wins.
- Latency: an accepted result in cycle N appears on rd_* with rd_we_o=1 in cycle N+1 (registered outputs). With no accept, rd_we_o=0 next cycle and rd_addr_o/rd_data_o hold their values. Throughput is one write per cycle.
- x0: a result with rd_addr=0 is still accepted (handshake completes), but rd_we_o stays 0.
- Load formatting: byte selects lane lsu_offset_i[1:0]; half selects the upper half if lsu_offset_i[1]=1, otherwise the lower half (offset[0] ignored); word ignores offset. Extension is zero when lsu_unsigned_i=1, sign otherwise.
- Scoreboard: issue_i with nonzero issue_rd_addr_i sets busy[rd] at the edge. busy[rd] clears at the edge ending a cycle where rd_we_o=1 and rd_addr_o=rd, i.e. the same edge at which the regfile captures the data. If a set and a clear hit the same register in the same cycle, the set wins.
- stall_o (combinational) = busy[rs_addr_a_i] | busy[rs_addr_b_i] | (issue_i & busy[issue_rd_addr_i]). Index 0 never stalls. Issuing to an already-busy register is illegal; the bench asserts it never happens while stall_o is honoured.

Test Plan:
- Reset mid-stream: drive ALU valid, assert rst_ni low between edges -> rd_we_o=0 and busy_o=0 immediately, without waiting for an edge.
- ALU only: alu_rd_addr=5, result=0xDEADBEEF, accepted in cycle N -> cycle N+1 shows rd_addr_o=5, rd_data_o=0xDEADBEEF, rd_we_o=1; rd_we_o=0 in cycle N+2.
- Load formatting: rdata=0x80FF7F01. Byte signed offset 3 -> 0xFFFFFF80. Byte unsigned offset 2 -> 0x000000FF. Half signed offset 2 -> 0xFFFF80FF. Word -> 0x80FF7F01.
- Starvation with STARVE_LIMIT=2, both valid continuously: grants are LSU, LSU, ALU, LSU, LSU, ALU... Producers stay stalled until ready; no result is lost or duplicated.
- Scoreboard: issue rd=7 -> busy_o[7]=1 next cycle; decode rs_a=7 -> stall_o=1. ALU writes rd=7 -> busy_o[7] clears at the edge ending the rd_we_o cycle. In the same cycle, a new issue to rd=7 plus that clear leaves busy_o[7]=1.
- x0: an ALU result with rd=0 is accepted with alu_ready_o=1; rd_we_o stays 0 and busy_o[0] stays 0, including when issue_rd_addr_i=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU and LSU results onto the single regfile write
// port, formats load data, and tracks pending writes for decode hazard stalls.
module writeback_stage #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_addr_i,
    input  logic [31:0] alu_result_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_addr_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [1:0]  lsu_offset_i,
    input  logic        issue_i,
    input  logic [4:0]  issue_rd_addr_i,
    input  logic [4:0]  rs_addr_a_i,
    input  logic [4:0]  rs_addr_b_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_we_o,
    output logic [31:0] busy_o,
    output logic        stall_o
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          alu_grant;
    logic          lsu_grant;
    logic          accept;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          ext_bit;
    logic [31:0]   load_data;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   busy_q;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    // LSU wins unless the ALU has already lost STARVE_LIMIT cycles in a row.
    assign alu_grant   = alu_valid_i && (!lsu_valid_i || starve_cnt == CW'(STARVE_LIMIT));
    assign lsu_grant   = lsu_valid_i && !alu_grant;
    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;
    assign accept      = alu_grant || lsu_grant;

    assign byte_sel = lsu_rdata_i[{lsu_offset_i, 3'b000} +: 8];
    assign half_sel = lsu_offset_i[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        ext_bit   = 1'b0;
        load_data = lsu_rdata_i;
        case (lsu_size_i)
            2'b00: begin
                ext_bit   = !lsu_unsigned_i && byte_sel[7];
                load_data = {{24{ext_bit}}, byte_sel};
            end
            2'b01: begin
                ext_bit   = !lsu_unsigned_i && half_sel[15];
                load_data = {{16{ext_bit}}, half_sel};
            end
            default: load_data = lsu_rdata_i;
        endcase
    end

    assign wr_addr = alu_grant ? alu_rd_addr_i : lsu_rd_addr_i;
    assign wr_data = alu_grant ? alu_result_i  : load_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (alu_valid_i && !alu_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Writes to x0 complete the handshake but never raise the write enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr_o <= '0;
            rd_data_o <= '0;
            rd_we_o   <= 1'b0;
        end else begin
            rd_we_o <= accept && (wr_addr != 5'd0);
            if (accept) begin
                rd_addr_o <= wr_addr;
                rd_data_o <= wr_data;
            end
        end
    end

    // Clear lands on the same edge the regfile captures the data; a same-cycle set wins.
    assign clr_mask = rd_we_o ? (32'd1 << rd_addr_o) : 32'd0;
    assign set_mask = (issue_i && issue_rd_addr_i != 5'd0) ? (32'd1 << issue_rd_addr_i) : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    assign busy_o  = busy_q;
    assign stall_o = busy_q[rs_addr_a_i] | busy_q[rs_addr_b_i] | (issue_i & busy_q[issue_rd_addr_i]);

endmodule
